demux_router: RTL

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_slot.sv | 55 +++++
 rtl/demux_router.sv | 74 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the demux router slice.
//   SEL_W       channel select width
//   DROP_CNT_W  width of the optional discarded-word counter
//   DATA_W_DEF  default payload width
//   NCH_DEF     default number of output channels
//   slot_state_e  one-entry slot occupancy state
package demux_pkg;

  localparam int SEL_W      = 5;
  localparam int DROP_CNT_W = 16;
  localparam int DATA_W_DEF = 8;
  localparam int NCH_DEF    = 31;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding slot for a single router output channel.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   load         a word is transferred into this slot this cycle
//   load_data    the word being loaded
//   out_ready    downstream consumer takes the held word
//   out_valid    slot holds a word
//   out_data     held word (keeps its last value when empty)
//   slot_ready   slot can take a word this cycle (empty, or draining now)
//
// state      | meaning
// -----------+--------------------------------------------
// SLOT_EMPTY | no word held, out_valid low
// SLOT_FULL  | word held on out_data, out_valid high
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              slot_ready
);

  slot_state_e state, state_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
    end else begin
      state <= state_nx;
      if (load) out_data <= load_data;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      SLOT_EMPTY: if (load) state_nx = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !load) state_nx = SLOT_EMPTY;
      default:    state_nx = SLOT_EMPTY;
    endcase
  end

  assign out_valid  = (state == SLOT_FULL);
  // A full slot being drained this cycle can be refilled in the same cycle.
  assign slot_ready = (state == SLOT_EMPTY) || out_ready;

endmodule

// File: rtl/demux_router.sv
// demux_router: routes one input stream to NCH one-entry output slots by in_sel.
// Words addressed past the last channel are accepted and discarded.
// Optional feature macro: DEMUX_DROP_CNT_EN adds the saturating drop_cnt output.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   in_valid     upstream word valid
//   in_ready     router accepts the word this cycle (independent of in_valid)
//   in_sel       destination channel index
//   in_data      payload
//   out_valid    per-channel word present
//   out_ready    per-channel consumer ready
//   out_data     channel i at [i*DATA_W +: DATA_W]
//   drop_cnt     discarded-word count (only with DEMUX_DROP_CNT_EN)
module demux_router
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NCH    = NCH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DATA_W-1:0]     in_data,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  output logic [NCH*DATA_W-1:0] out_data
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic [NCH-1:0]      slot_ready;
  logic [(1<<SEL_W)-1:0] rdy_pad;
  logic                xfer_in;

  // Unused select codes read as ready so out-of-range words are always taken.
  always_comb begin
    rdy_pad          = '1;
    rdy_pad[NCH-1:0] = slot_ready;
  end

  assign in_ready = !reset && rdy_pad[in_sel];
  assign xfer_in  = in_valid && in_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (xfer_in && (in_sel == SEL_W'(i))),
      .load_data  (in_data),
      .out_ready  (out_ready[i]),
      .out_valid  (out_valid[i]),
      .out_data   (out_data[i*DATA_W +: DATA_W]),
      .slot_ready (slot_ready[i])
    );
  end

`ifdef DEMUX_DROP_CNT_EN
  logic sel_oob;
  assign sel_oob = (int'(in_sel) >= NCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (xfer_in && sel_oob && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule
